vga_timing_gen: RTL and testbench

Generates the 640x480@60 raster that drives the pixel generator.
- Produces the col/row/valid scan that the screen generator consumes.
- Receives that generator's 6-bit rgb back.
- Drives the VGA connector (hsync, vsync, rgb_out), with sync and blanking pipelined so they stay aligned with rgb whatever the generator's latency.
- Provides frame_tick and line_tick for game-state logic (note scroll, score update).

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_timing_gen_sync_delay.sv | 35 +++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and helpers for the raster
// generator and its consumers.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    typedef logic [5:0] rgb6_t;

    localparam rgb6_t BLACK = 6'h00;
    localparam rgb6_t WHITE = 6'h3F;

    function automatic int vga_total(input int visible, input int front,
                                     input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register with asynchronous reset to a chosen value,
// used to keep sync and blanking aligned with the colour path.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_depth_err
        $error("sync_delay: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counter with sync/blanking delayed to line up with the
// colour returned by the pixel generator.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int RGB_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    output logic       line_tick,
    output logic       frame_tick,
    input  rgb6_t      rgb_in,
    output rgb6_t      rgb_out,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int DEPTH   = RGB_LATENCY + 1;

    if (H_TOTAL > 1024) begin : g_h_err
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_err
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    // 11-bit bounds so a full 1024 total cannot wrap a comparison constant
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [2:0] DLY_RST = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

    logic [9:0] col_nxt;
    logic [9:0] row_nxt;
    logic       vld_nxt;
    logic       hs_lvl;
    logic       vs_lvl;
    logic       vld_al;

    always_comb begin
        col_nxt = col + 10'd1;
        row_nxt = row;
        if (col == H_LAST) begin
            col_nxt = '0;
            row_nxt = (row == V_LAST) ? '0 : row + 10'd1;
        end
    end

    assign vld_nxt = ({1'b0, col_nxt} < H_VIS) && ({1'b0, row_nxt} < V_VIS);

    // Stage 0: counters and their decodes, all from next-state counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= H_LAST;
            row        <= V_LAST;
            valid      <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            col        <= col_nxt;
            row        <= row_nxt;
            valid      <= vld_nxt;
            line_tick  <= (col_nxt == '0);
            frame_tick <= (col_nxt == '0) && (row_nxt == '0);
        end
    end

    assign hs_lvl = ({1'b0, col} >= HS_BEG && {1'b0, col} < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs_lvl = ({1'b0, row} >= VS_BEG && {1'b0, row} < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // Delaying vld_nxt by DEPTH equals delaying valid by RGB_LATENCY,
    // which is when the matching rgb_in arrives.
    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (DEPTH),
        .RST_VAL (DLY_RST)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({hs_lvl, vs_lvl, vld_nxt}),
        .dout  ({hsync, vsync, vld_al})
    );

    // Stage D: blanked colour register, aligned with hsync/vsync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out <= BLACK;
        end else begin
            rgb_out <= vld_al ? rgb_in : BLACK;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default raster at latencies 0/1/3 plus a miniature raster
// for frame-level timing within a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // latency-1 default build
    logic [9:0] c1, r1;
    logic v1, lt1, ft1, hs1, vs1;
    logic [5:0] ri1, ro1, g1;
    // latency-0 default build
    logic [9:0] c0, r0;
    logic v0, lt0, ft0, hs0, vs0;
    logic [5:0] ri0, ro0;
    // latency-3 default build
    logic [9:0] c3, r3;
    logic v3, lt3, ft3, hs3, vs3;
    logic [5:0] ri3, ro3, g3a, g3b, g3c;
    // miniature build: 8/2/3/2 x 4/1/2/1 -> 15 x 8
    logic [9:0] cs, rs;
    logic vs_v, lts, fts, hss, vss;
    logic [5:0] ris, ros, gs;

    vga_timing_gen u_d1 (.clk(clk), .reset(reset), .col(c1), .row(r1), .valid(v1),
        .line_tick(lt1), .frame_tick(ft1), .rgb_in(ri1), .rgb_out(ro1), .hsync(hs1), .vsync(vs1));
    vga_timing_gen #(.RGB_LATENCY(0)) u_d0 (.clk(clk), .reset(reset), .col(c0), .row(r0), .valid(v0),
        .line_tick(lt0), .frame_tick(ft0), .rgb_in(ri0), .rgb_out(ro0), .hsync(hs0), .vsync(vs0));
    vga_timing_gen #(.RGB_LATENCY(3)) u_d3 (.clk(clk), .reset(reset), .col(c3), .row(r3), .valid(v3),
        .line_tick(lt3), .frame_tick(ft3), .rgb_in(ri3), .rgb_out(ro3), .hsync(hs3), .vsync(vs3));
    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_ds (
        .clk(clk), .reset(reset), .col(cs), .row(rs), .valid(vs_v),
        .line_tick(lts), .frame_tick(fts), .rgb_in(ris), .rgb_out(ros), .hsync(hss), .vsync(vss));

    // Generator models: colour = col[5:0] after the build's latency; the
    // latency-1 model drives 3F during horizontal blanking to test gating.
    always @(posedge clk) begin
        g1  <= (c1 >= 10'd640) ? 6'h3F : c1[5:0];
        g3a <= c3[5:0];
        g3b <= g3a;
        g3c <= g3b;
        gs  <= cs[5:0];
    end
    assign ri1 = g1;
    assign ri0 = c0[5:0];
    assign ri3 = g3c;
    assign ris = gs;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int col;
        int row;
        int vld;
        int lt;
        int ft;
        int hs;
        int rgb;
    } vec_t;

    vec_t vt[15];

    initial begin
        int hs_low, v_cnt, lt_a, lt_b, blank_bad, vis_bad;
        int fs_a, fs_b, vs_low, vs_first, row_max;
        bit found;

        vt[0]  = '{1,   0,   0, 1, 1, 1, 1, 0};
        vt[1]  = '{2,   1,   0, 1, 0, 0, 1, 0};
        vt[2]  = '{3,   2,   0, 1, 0, 0, 1, 0};
        vt[3]  = '{40,  39,  0, 1, 0, 0, 1, 37};
        vt[4]  = '{640, 639, 0, 1, 0, 0, 1, 61};
        vt[5]  = '{641, 640, 0, 0, 0, 0, 1, 62};
        vt[6]  = '{642, 641, 0, 0, 0, 0, 1, 63};
        vt[7]  = '{643, 642, 0, 0, 0, 0, 1, 0};
        vt[8]  = '{658, 657, 0, 0, 0, 0, 1, 0};
        vt[9]  = '{659, 658, 0, 0, 0, 0, 0, 0};
        vt[10] = '{754, 753, 0, 0, 0, 0, 0, 0};
        vt[11] = '{755, 754, 0, 0, 0, 0, 1, 0};
        vt[12] = '{800, 799, 0, 0, 0, 0, 1, 0};
        vt[13] = '{801, 0,   1, 1, 1, 0, 1, 0};
        vt[14] = '{804, 3,   1, 1, 0, 0, 1, 1};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst col", int'(c1), 799);
        chk("rst row", int'(r1), 524);
        chk("rst valid", int'(v1), 0);
        chk("rst ticks", int'({lt1, ft1}), 0);
        chk("rst hsync", int'(hs1), 1);
        chk("rst vsync", int'(vs1), 1);
        chk("rst rgb", int'(ro1), 0);
        chk("rst small col/row", int'({cs, rs}), int'({10'd14, 10'd7}));
        reset = 1'b0;

        hs_low = 0; v_cnt = 0; lt_a = 0; lt_b = 0; blank_bad = 0; vis_bad = 0;
        fs_a = 0; fs_b = 0; vs_low = 0; vs_first = 0; row_max = 0;

        for (int n = 1; n <= 820; n++) begin
            @(negedge clk);
            for (int k = 0; k < 15; k++) begin
                if (vt[k].n == n) begin
                    chk($sformatf("vec%0d col", k), int'(c1), vt[k].col);
                    chk($sformatf("vec%0d row", k), int'(r1), vt[k].row);
                    chk($sformatf("vec%0d valid", k), int'(v1), vt[k].vld);
                    chk($sformatf("vec%0d line_tick", k), int'(lt1), vt[k].lt);
                    chk($sformatf("vec%0d frame_tick", k), int'(ft1), vt[k].ft);
                    chk($sformatf("vec%0d hsync", k), int'(hs1), vt[k].hs);
                    chk($sformatf("vec%0d rgb_out", k), int'(ro1), vt[k].rgb);
                end
            end
            if (n <= 800) begin
                if (!hs1) hs_low++;
                if (v1) v_cnt++;
            end
            if (lt1) begin
                if (lt_a == 0) lt_a = n;
                else if (lt_b == 0) lt_b = n;
            end
            if (n >= 643 && n <= 802 && ro1 != 6'd0) blank_bad++;
            if (n >= 3 && n <= 642 && int'(ro1) != ((n - 3) & 63)) vis_bad++;
            if (n >= 803 && int'(ro1) != ((n - 803) & 63)) vis_bad++;
            // latency-0 and latency-3 offsets for pixel col 37 and hsync onset
            if (n == 38) chk("lat0 rgb before", int'(ro0), 36);
            if (n == 39) chk("lat0 rgb at D", int'(ro0), 37);
            if (n == 41) chk("lat3 rgb before", int'(ro3), 36);
            if (n == 42) chk("lat3 rgb at D", int'(ro3), 37);
            if (n == 657) chk("lat0 hsync before", int'(hs0), 1);
            if (n == 658) chk("lat0 hsync onset", int'(hs0), 0);
            if (n == 660) chk("lat3 hsync before", int'(hs3), 1);
            if (n == 661) chk("lat3 hsync onset", int'(hs3), 0);
            // miniature frame
            if (fts) begin
                if (fs_a == 0) fs_a = n;
                else if (fs_b == 0) fs_b = n;
            end
            if (n <= 240 && !vss) begin
                vs_low++;
                if (vs_first == 0) vs_first = n;
            end
            if (int'(rs) > row_max) row_max = int'(rs);
        end

        chk("line_tick first", lt_a, 1);
        chk("line period", lt_b - lt_a, 800);
        chk("hsync low clocks", hs_low, 96);
        chk("valid high clocks", v_cnt, 640);
        chk("blank with 3F in", blank_bad, 0);
        chk("visible pixel path", vis_bad, 0);
        chk("small frame_tick first", fs_a, 1);
        chk("small frame period", fs_b - fs_a, 120);
        chk("small vsync low clocks", vs_low, 60);
        chk("small vsync onset", vs_first, 78);
        chk("small row max", row_max, 7);

        // asynchronous reset mid-line, away from the clock edge
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (c1 == 10'd300) found = 1'b1;
        end
        chk("reach col 300", int'(found), 1);
        chk("mid row", int'(r1), 1);
        #1 reset = 1'b1;
        #1;
        chk("async col", int'(c1), 799);
        chk("async row", int'(r1), 524);
        chk("async valid", int'(v1), 0);
        chk("async hsync", int'(hs1), 1);
        chk("async vsync", int'(vs1), 1);
        chk("async small row", int'(rs), 7);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("restart col/row", int'({c1, r1}), 0);
        chk("restart ticks", int'({v1, lt1, ft1}), 7);
        chk("restart small ticks", int'({cs, rs, fts}), 1);
        @(negedge clk);
        chk("restart rgb blank", int'(ro1), 0);
        @(negedge clk);
        chk("restart rgb col0", int'(ro1), 0);
        @(negedge clk);
        chk("restart rgb col1", int'(ro1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
